// File: rtl/ro_meter_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency meter.
// The state enum is common to the top-level FSM and any tooling that decodes it.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int GATE_W_DEF      = 16;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/ro_freq_meter_if.sv
// Result port of the frequency meter: count plus qualifiers on a valid/ready handshake.
// The master side is the meter, the slave side is the result consumer.
interface ro_freq_meter_if #(
  parameter int CNT_W = ro_meter_pkg::CNT_W_DEF
);

  logic [CNT_W-1:0] count_o;
  logic             count_valid_o;
  logic             count_ready_i;
  logic             saturated_o;
  logic             overrun_o;

  modport master (
    output count_o,
    output count_valid_o,
    output saturated_o,
    output overrun_o,
    input  count_ready_i
  );

  modport slave (
    input  count_o,
    input  count_valid_o,
    input  saturated_o,
    input  overrun_o,
    output count_ready_i
  );

endinterface

// File: rtl/ro_sync_edge.sv
// Brings the asynchronous divided RO clock into clk_i and emits a registered
// one-cycle pulse per rising edge, SYNC_STAGES+1 cycles after the input rises.
module ro_sync_edge #(
  parameter int SYNC_STAGES = ro_meter_pkg::SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Counts synchronized ring-oscillator edges over a gate window of clk_i cycles
// and presents the result through a valid/ready port with saturation and overrun flags.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int GATE_W      = GATE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ro_clk_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  input  logic              start_i,
  input  logic              cont_i,
  output logic              busy_o,
  ro_freq_meter_if.master   res_if
);

  localparam logic [CNT_W-1:0]  CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  state_e            state_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sat_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              sat_out_q;
  logic              overrun_q;

  logic              ro_edge;
  logic [CNT_W-1:0]  cnt_d;
  logic              sat_d;
  logic [GATE_W-1:0] gate_d;
  logic              load_d;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(ro_clk_i),
    .edge_o (ro_edge)
  );

  // Window counter value including this cycle's pulse, so the last COUNT cycle's edge lands in the result.
  always_comb begin
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    gate_d = (gate_cycles_i == '0) ? GATE_ONE : gate_cycles_i;
    load_d = (state_q == COUNT) && (gate_q == GATE_ONE);
    if (ro_edge && (cnt_q != CNT_TOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_TOP) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      sat_out_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i || cont_i) begin
            state_q <= COUNT;
            gate_q  <= gate_d;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end
        end
        COUNT: begin
          cnt_q <= cnt_d;
          sat_q <= sat_d;
          if (gate_q == GATE_ONE) begin
            state_q <= REPORT;
          end else begin
            gate_q <= gate_q - 1'b1;
          end
        end
        REPORT: begin
          if (cont_i) begin
            state_q <= COUNT;
            gate_q  <= gate_d;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A simultaneous accept frees the slot, so only an unaccepted result counts as overwritten.
      if (load_d) begin
        count_q   <= cnt_d;
        sat_out_q <= sat_d;
        valid_q   <= 1'b1;
        if (valid_q && !res_if.count_ready_i) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && res_if.count_ready_i) begin
        valid_q <= 1'b0;
      end

      if ((state_q == IDLE) && start_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign busy_o               = (state_q != IDLE);
  assign res_if.count_o       = count_q;
  assign res_if.count_valid_o = valid_q;
  assign res_if.saturated_o   = sat_out_q;
  assign res_if.overrun_o     = overrun_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: table of single-shot windows, hand-written
// continuous/handshake/reset sequences, and randomized windows against an edge-list model.
module tb_ro_freq_meter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ro;
  logic [15:0] gate;
  logic        start;
  logic        cont;
  logic        start4;
  logic        cont4;
  logic        busy;
  logic        busy4;

  ro_freq_meter_if #(.CNT_W(16)) res ();
  ro_freq_meter_if #(.CNT_W(4))  res4 ();

  ro_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .ro_clk_i(ro), .gate_cycles_i(gate),
    .start_i(start), .cont_i(cont), .busy_o(busy), .res_if(res)
  );

  ro_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(S)) dut4 (
    .clk_i(clk), .rst_i(rst), .ro_clk_i(ro), .gate_cycles_i(gate),
    .start_i(start4), .cont_i(cont4), .busy_o(busy4), .res_if(res4)
  );

  always #5 clk = ~clk;

  // cyc is the index of the most recent rising clock edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  hiLen = 3;
  int  loLen = 3;
  bit  roEnable = 1'b0;
  int  rises[$];
  int  phaseCnt = 0;

  // RO stimulus changes on the falling edge; each rise is logged with the clock edge that first sees it.
  initial begin
    ro = 1'b0;
    forever begin
      @(negedge clk);
      if (!roEnable) begin
        ro = 1'b0;
        phaseCnt = 0;
      end else begin
        phaseCnt++;
        if (ro && phaseCnt >= hiLen) begin
          ro = 1'b0;
          phaseCnt = 0;
        end else if (!ro && phaseCnt >= loLen) begin
          ro = 1'b1;
          phaseCnt = 0;
          rises.push_back(cyc + 1);
        end
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int gateEff(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  // An RO rise first seen at edge r is counted at edge r+S+1; the window counts at edges k+1..k+gp.
  function automatic int modelCount(input int k, input int gp);
    int n = 0;
    foreach (rises[i]) begin
      if ((rises[i] + S + 1 >= k + 1) && (rises[i] + S + 1 <= k + gp)) n++;
    end
    return n;
  endfunction

  task automatic setRo(input int hi, input int lo, input bit en);
    hiLen = hi;
    loLen = lo;
    roEnable = en;
    repeat (2 * (hi + lo) + 4) @(negedge clk);
  endtask

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int g, output int k, output int gotCount,
                               output int gotSat, output int busyCycles, output int timedOut);
    @(negedge clk);
    gate  = g[15:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    busyCycles = 0;
    timedOut = 1;
    gotCount = -1;
    gotSat = -1;
    for (int i = 0; i < g + 20; i++) begin
      if (!busy) begin
        timedOut = 0;
        break;
      end
      busyCycles++;
      if (res.count_valid_o) begin
        gotCount = int'(res.count_o);
        gotSat   = int'(res.saturated_o);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    bit en;
    int gate;
    int expCount;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int k, gotCount, gotSat, busyCycles, timedOut;
    int l1, l2, g, expCnt;

    vecs[0] = '{3, 3, 1'b1, 60, 10};
    vecs[1] = '{2, 2, 1'b1, 100, 25};
    vecs[2] = '{4, 4, 1'b1, 64, 8};
    vecs[3] = '{2, 4, 1'b1, 60, 10};
    vecs[4] = '{5, 3, 1'b1, 80, 10};
    vecs[5] = '{3, 3, 1'b0, 0, 0};
    vecs[6] = '{3, 3, 1'b0, 37, 0};

    rst = 1'b1;
    gate = '0;
    start = 1'b0;
    cont = 1'b0;
    start4 = 1'b0;
    cont4 = 1'b0;
    res.count_ready_i = 1'b1;
    res4.count_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset valid", int'(res.count_valid_o), 0);
    checkOutput("reset count", int'(res.count_o), 0);
    checkOutput("reset saturated", int'(res.saturated_o), 0);
    checkOutput("reset overrun", int'(res.overrun_o), 0);

    for (int v = 0; v < 7; v++) begin
      setRo(vecs[v].hi, vecs[v].lo, vecs[v].en);
      applyStimulus(vecs[v].gate, k, gotCount, gotSat, busyCycles, timedOut);
      checkOutput($sformatf("vec%0d timeout", v), timedOut, 0);
      checkOutput($sformatf("vec%0d count", v), gotCount, vecs[v].expCount);
      checkOutput($sformatf("vec%0d saturated", v), gotSat, 0);
      checkOutput($sformatf("vec%0d busy cycles", v), busyCycles, gateEff(vecs[v].gate) + 1);
    end

    // Same 100-cycle window on the 16-bit and the 4-bit counter.
    setRo(2, 2, 1'b1);
    @(negedge clk);
    gate = 16'd100;
    start = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
    timedOut = 1;
    for (int i = 0; i < 130; i++) begin
      if (res4.count_valid_o) begin
        timedOut = 0;
        break;
      end
      @(negedge clk);
    end
    checkOutput("sat timeout", timedOut, 0);
    checkOutput("sat4 count", int'(res4.count_o), 15);
    checkOutput("sat4 saturated", int'(res4.saturated_o), 1);
    checkOutput("sat16 count", int'(res.count_o), 25);
    checkOutput("sat16 saturated", int'(res.saturated_o), 0);
    repeat (4) @(negedge clk);

    // Continuous mode with no consumer: second window overwrites the first.
    res.count_ready_i = 1'b0;
    @(negedge clk);
    gate = 16'd20;
    cont = 1'b1;
    @(negedge clk);
    k = cyc;
    l1 = k + 20;
    waitCyc(l1);
    checkOutput("cont w1 valid", int'(res.count_valid_o), 1);
    checkOutput("cont w1 count", int'(res.count_o), 5);
    checkOutput("cont w1 overrun", int'(res.overrun_o), 0);
    gate = 16'd40;
    @(negedge clk);
    cont = 1'b0;
    l2 = l1 + 1 + 40;
    waitCyc(l2);
    checkOutput("cont w2 valid", int'(res.count_valid_o), 1);
    checkOutput("cont w2 count", int'(res.count_o), 10);
    checkOutput("cont w2 overrun", int'(res.overrun_o), 1);
    waitCyc(l2 + 1);
    checkOutput("cont end busy", int'(busy), 0);
    res.count_ready_i = 1'b1;
    @(negedge clk);
    res.count_ready_i = 1'b0;
    checkOutput("cont accepted valid", int'(res.count_valid_o), 0);
    gate = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start clears overrun", int'(res.overrun_o), 0);
    checkOutput("start busy", int'(busy), 1);
    res.count_ready_i = 1'b1;
    repeat (16) @(negedge clk);

    // Accept coinciding with the next load keeps valid high without overrun.
    res.count_ready_i = 1'b0;
    @(negedge clk);
    gate = 16'd20;
    cont = 1'b1;
    @(negedge clk);
    k = cyc;
    l1 = k + 20;
    waitCyc(l1);
    gate = 16'd24;
    @(negedge clk);
    cont = 1'b0;
    l2 = l1 + 1 + 24;
    waitCyc(l2 - 1);
    checkOutput("accload old valid", int'(res.count_valid_o), 1);
    checkOutput("accload old count", int'(res.count_o), 5);
    res.count_ready_i = 1'b1;
    @(negedge clk);
    res.count_ready_i = 1'b0;
    checkOutput("accload new valid", int'(res.count_valid_o), 1);
    checkOutput("accload new count", int'(res.count_o), 6);
    checkOutput("accload overrun", int'(res.overrun_o), 0);
    @(negedge clk);
    checkOutput("accload held valid", int'(res.count_valid_o), 1);

    // Reset in the middle of a window aborts it and clears the held result.
    gate = 16'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst busy", int'(busy), 0);
    checkOutput("midrst valid", int'(res.count_valid_o), 0);
    checkOutput("midrst count", int'(res.count_o), 0);
    checkOutput("midrst overrun", int'(res.overrun_o), 0);
    repeat (70) @(negedge clk);
    checkOutput("midrst no result", int'(res.count_valid_o), 0);
    checkOutput("midrst stays idle", int'(busy), 0);

    res.count_ready_i = 1'b1;
    for (int it = 0; it < 12; it++) begin
      g = int'($urandom_range(0, 90));
      setRo(int'($urandom_range(2, 5)), int'($urandom_range(2, 5)), 1'b1);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      applyStimulus(g, k, gotCount, gotSat, busyCycles, timedOut);
      expCnt = modelCount(k, gateEff(g));
      checkOutput($sformatf("rand%0d timeout", it), timedOut, 0);
      checkOutput($sformatf("rand%0d count (G=%0d)", it, g), gotCount, expCnt);
      checkOutput($sformatf("rand%0d busy cycles", it), busyCycles, gateEff(g) + 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
